// File: rtl/nios_mult_pkg.sv
// Shared mode encodings, operand-extension helpers and stage control type
// for the pipelined NiosII multiply unit.
package nios_mult_pkg;

  localparam logic [1:0] MODE_LO    = 2'b00;
  localparam logic [1:0] MODE_HI_SS = 2'b01;
  localparam logic [1:0] MODE_HI_SU = 2'b10;
  localparam logic [1:0] MODE_HI_UU = 2'b11;

  // Control half of every stage payload; tag and data widths are
  // parameter-dependent and are attached inside the unit itself.
  typedef struct packed {
    logic       valid;
    logic [1:0] mode;
  } stage_ctrl_t;

  function automatic logic src1_signed(input logic [1:0] mode);
    return (mode == MODE_HI_SS) || (mode == MODE_HI_SU);
  endfunction

  function automatic logic src2_signed(input logic [1:0] mode);
    return (mode == MODE_HI_SS) && (mode != MODE_HI_UU);
  endfunction

  // Bit DATA_W of the extended operand: the MSB when signed, else zero.
  function automatic logic ext_bit(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/nios_mult_pp.sv
// Registered unsigned W x W multiplier with load enable; one DSP block each.
module nios_mult_pp #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
  end

endmodule

// File: rtl/nios_mult_pipe.sv
// Pipelined signed/unsigned multiply unit with valid/ready handshake, flush
// and selectable low/high product half.
module nios_mult_pipe
  import nios_mult_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned HALF_W = DATA_W / 2;

  logic advance;
  logic accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance && !flush;

  // Extension bits sit at weight 2^DATA_W, so modulo 2^(2*DATA_W) they only
  // subtract the other operand from the high half; fold both into one term.
  logic              ext1;
  logic              ext2;
  logic [DATA_W-1:0] corr_in;

  always_comb begin
    ext1    = ext_bit(in_src1[DATA_W-1], src1_signed(in_mode));
    ext2    = ext_bit(in_src2[DATA_W-1], src2_signed(in_mode));
    corr_in = (ext1 ? in_src2 : '0) + (ext2 ? in_src1 : '0);
  end

  stage_ctrl_t       s1_ctrl;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] s1_corr;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ctrl <= '0;
      s1_tag  <= '0;
      s1_corr <= '0;
    end else begin
      if (advance || flush) s1_ctrl.valid <= accept;
      if (accept) begin
        s1_ctrl.mode <= in_mode;
        s1_tag       <= in_tag;
        s1_corr      <= corr_in;
      end
    end
  end

  nios_mult_pp #(.W(HALF_W)) u_pp_ll (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[HALF_W-1:0]), .p(pp_ll)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_lh (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[DATA_W-1:HALF_W]), .p(pp_lh)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_hl (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[HALF_W-1:0]), .p(pp_hl)
  );
  nios_mult_pp #(.W(HALF_W)) u_pp_hh (
    .clk(clk), .reset(reset), .en(accept),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[DATA_W-1:HALF_W]), .p(pp_hh)
  );

  logic [2*DATA_W-1:0] full_prod;
  logic [DATA_W-1:0]   s1_result;

  always_comb begin
    full_prod = {pp_hh, pp_ll}
              + {{HALF_W{1'b0}}, pp_lh, {HALF_W{1'b0}}}
              + {{HALF_W{1'b0}}, pp_hl, {HALF_W{1'b0}}};
    s1_result = (s1_ctrl.mode == MODE_LO) ? full_prod[DATA_W-1:0]
                                          : full_prod[2*DATA_W-1:DATA_W] - s1_corr;
  end

  if (LATENCY == 1) begin : g_single
    // Data registers only load on accept, so the combinational sum holds
    // its value while out_valid is low.
    assign out_valid  = s1_ctrl.valid;
    assign out_result = s1_result;
    assign out_tag    = s1_tag;
  end else begin : g_chain
    localparam int unsigned N = LATENCY - 1;

    logic              dly_valid [N];
    logic [DATA_W-1:0] dly_res   [N];
    logic [TAG_W-1:0]  dly_tag   [N];
    logic              src_valid [N];
    logic [DATA_W-1:0] src_res   [N];
    logic [TAG_W-1:0]  src_tag   [N];

    always_comb begin
      src_valid[0] = s1_ctrl.valid;
      src_res[0]   = s1_result;
      src_tag[0]   = s1_tag;
      for (int unsigned i = 1; i < N; i++) begin
        src_valid[i] = dly_valid[i-1];
        src_res[i]   = dly_res[i-1];
        src_tag[i]   = dly_tag[i-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < N; i++) begin
          dly_valid[i] <= 1'b0;
          dly_res[i]   <= '0;
          dly_tag[i]   <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < N; i++) begin
          if (flush) begin
            dly_valid[i] <= 1'b0;
          end else if (advance) begin
            dly_valid[i] <= src_valid[i];
            if (src_valid[i]) begin
              dly_res[i] <= src_res[i];
              dly_tag[i] <= src_tag[i];
            end
          end
        end
      end
    end

    assign out_valid  = dly_valid[N-1];
    assign out_result = dly_res[N-1];
    assign out_tag    = dly_tag[N-1];
  end

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Directed and randomized bench for nios_mult_pipe: a 32-bit/latency-2 unit
// for directed steps plus four extra configurations for the random sweep.
module tb_nios_mult_pipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Directed-test unit
  logic        m_flush = 1'b0, m_in_valid = 1'b0, m_out_ready = 1'b1;
  logic        m_in_ready, m_out_valid;
  logic [31:0] m_src1 = '0, m_src2 = '0, m_out_result;
  logic [1:0]  m_mode = '0;
  logic [4:0]  m_tag = '0, m_out_tag;

  nios_mult_pipe #(.DATA_W(32), .LATENCY(2), .TAG_W(5)) u_dut (
    .clk(clk), .reset(reset), .flush(m_flush),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_src1(m_src1), .in_src2(m_src2), .in_mode(m_mode), .in_tag(m_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_result(m_out_result), .out_tag(m_out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: extend to w+1 bits by mode, multiply, pick the half.
  function automatic logic [31:0] ref_mul(input int unsigned w, input logic [1:0] mode,
                                          input logic [31:0] a, input logic [31:0] b);
    longint          ea, eb, p;
    longint unsigned mask;
    logic [63:0]     r;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'({32'd0, a} & mask);
    eb = longint'({32'd0, b} & mask);
    if ((mode == 2'b01 || mode == 2'b10) && a[w-1]) ea = ea - longint'(mask) - 1;
    if (mode == 2'b01 && b[w-1]) eb = eb - longint'(mask) - 1;
    p = ea * eb;
    r = (mode == 2'b00) ? (p & mask) : ((p >> w) & mask);
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_8000;
      default: return $urandom();
    endcase
  endfunction

  // Random-sweep units, all fed from the same stimulus
  logic        r_flush = 1'b0, r_valid = 1'b0, r_out_ready = 1'b1;
  logic [31:0] r_src1 = '0, r_src2 = '0;
  logic [1:0]  r_mode = '0;
  logic [4:0]  r_tag = '0;
  logic        sweep_on = 1'b0, drain_chk = 1'b0;

  localparam int unsigned NCFG = 4;
  localparam int unsigned CFG_W [NCFG] = '{32, 16, 32, 16};
  localparam int unsigned CFG_L [NCFG] = '{1, 2, 3, 4};

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned W = CFG_W[g];
    logic         ir, ov;
    logic [W-1:0] res;
    logic [4:0]   otag;
    exp_t         q[$];
    logic         drained = 1'b0;

    nios_mult_pipe #(.DATA_W(W), .LATENCY(CFG_L[g]), .TAG_W(5)) u_rnd (
      .clk(clk), .reset(reset), .flush(r_flush),
      .in_valid(r_valid), .in_ready(ir),
      .in_src1(r_src1[W-1:0]), .in_src2(r_src2[W-1:0]), .in_mode(r_mode), .in_tag(r_tag),
      .out_valid(ov), .out_ready(r_out_ready), .out_result(res), .out_tag(otag)
    );

    always @(negedge clk) begin : sb
      exp_t e;
      if (reset) begin
        q.delete();
      end else if (sweep_on) begin
        check($sformatf("cfg%0d_in_ready", g), ir, !ov || r_out_ready);
        if (ov && r_out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d_spurious", g), ov, 1'b0);
          end else begin
            e = q.pop_front();
            check($sformatf("cfg%0d_result", g), res, e.res[W-1:0]);
            check($sformatf("cfg%0d_tag", g), otag, e.tag);
          end
        end
        if (r_flush) q.delete();
        else if (r_valid && (!ov || r_out_ready)) begin
          e.res = ref_mul(W, r_mode, r_src1, r_src2);
          e.tag = r_tag;
          q.push_back(e);
        end
        if (drain_chk && !drained) begin
          check($sformatf("cfg%0d_drain", g), q.size(), 0);
          drained = 1'b1;
        end
      end
    end
  end

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] mode, input logic [4:0] tag, input logic [31:0] exp);
    int unsigned n;
    m_in_valid = 1'b1; m_src1 = a; m_src2 = b; m_mode = mode; m_tag = tag; m_out_ready = 1'b1;
    tick();
    m_in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 10) begin
      tick();
      n++;
    end
    check({name, "_valid"}, m_out_valid, 1'b1);
    check({name, "_result"}, m_out_result, exp);
    check({name, "_tag"}, m_out_tag, tag);
    tick();
  endtask

  initial begin : main
    int unsigned sent, exp_tag, stall_left;
    logic        stalled_once;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", m_out_valid, 1'b0);
    check("rst_out_result", m_out_result, 32'h0);
    check("rst_out_tag", m_out_tag, 5'h0);
    #3 reset = 1'b0;
    tick();
    check("rst_in_ready", m_in_ready, 1'b1);

    // Basic latency: 7*6, tag 3
    m_in_valid = 1'b1; m_src1 = 32'd7; m_src2 = 32'd6; m_mode = 2'b00; m_tag = 5'd3;
    m_out_ready = 1'b1;
    tick();
    m_in_valid = 1'b0;
    check("lat_early_valid", m_out_valid, 1'b0);
    tick();
    check("lat_valid", m_out_valid, 1'b1);
    check("lat_result", m_out_result, 32'h0000_002A);
    check("lat_tag", m_out_tag, 5'd3);
    tick();
    check("lat_consumed", m_out_valid, 1'b0);

    // All modes on all-ones operands, then the 0x80000000 corner
    run_one("ones_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd0, 32'h0000_0001);
    run_one("ones_ss", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 5'd1, 32'h0000_0000);
    run_one("ones_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 5'd2, 32'hFFFF_FFFF);
    run_one("ones_uu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd3, 32'hFFFF_FFFE);
    run_one("min_ss", 32'h8000_0000, 32'h8000_0000, 2'b01, 5'd4, 32'h4000_0000);
    run_one("min_uu", 32'h8000_0000, 32'h8000_0000, 2'b11, 5'd5, 32'h4000_0000);
    run_one("min_lo", 32'h8000_0000, 32'h8000_0000, 2'b00, 5'd6, 32'h0000_0000);

    // Backpressure: 4 ops (tag t computes (t+1)*10), 3-cycle stall at first result
    sent = 0; exp_tag = 0; stall_left = 0; stalled_once = 1'b0;
    hold_res = '0; hold_tag = '0;
    for (int cyc = 0; cyc < 30 && exp_tag < 4; cyc++) begin
      m_in_valid = (sent < 4);
      m_src1 = sent + 1; m_src2 = 32'd10; m_mode = 2'b00; m_tag = sent[4:0];
      if (m_out_valid && !stalled_once) begin
        stall_left = 3; stalled_once = 1'b1;
        hold_res = m_out_result; hold_tag = m_out_tag;
      end
      m_out_ready = (stall_left == 0);
      #1;
      check("bp_in_ready", m_in_ready, !m_out_valid || m_out_ready);
      if (stall_left == 3) check("bp_in_ready_drop", m_in_ready, 1'b0);
      if (stall_left > 0 && stall_left < 3) begin
        check("bp_hold_result", m_out_result, hold_res);
        check("bp_hold_tag", m_out_tag, hold_tag);
      end
      if (m_out_valid && m_out_ready) begin
        check("bp_order_tag", m_out_tag, exp_tag);
        check("bp_result", m_out_result, (exp_tag + 1) * 10);
        exp_tag++;
      end
      if (m_in_valid && (!m_out_valid || m_out_ready)) sent++;
      if (stall_left > 0) stall_left--;
      @(posedge clk);
      #1;
    end
    check("bp_all_out", exp_tag, 4);
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_no_dup", m_out_valid, 1'b0);
      tick();
    end

    // Flush with two ops in flight and a third offered during flush
    m_in_valid = 1'b1; m_src1 = 32'd3; m_src2 = 32'd5; m_mode = 2'b00; m_tag = 5'd5;
    tick();
    m_src1 = 32'd4; m_tag = 5'd6;
    tick();
    m_out_ready = 1'b0; m_flush = 1'b1; m_src1 = 32'd9; m_tag = 5'd7;
    tick();
    m_flush = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fl_no_valid", m_out_valid, 1'b0);
      tick();
    end
    // Flush on an idle unit: in_ready is high but the offer is still dropped
    m_flush = 1'b1; m_in_valid = 1'b1; m_tag = 5'd8;
    #1 check("fl_idle_in_ready", m_in_ready, 1'b1);
    tick();
    m_flush = 1'b0; m_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fl_idle_no_valid", m_out_valid, 1'b0);
      tick();
    end
    run_one("fl_after", 32'd11, 32'd13, 2'b00, 5'd9, 32'h0000_008F);

    // Async reset while a result is held at the output
    m_in_valid = 1'b1; m_src1 = 32'h0001_2345; m_src2 = 32'h11; m_mode = 2'b00; m_tag = 5'h1A;
    tick();
    m_in_valid = 1'b0; m_out_ready = 1'b0;
    tick();
    check("ar_pre_valid", m_out_valid, 1'b1);
    m_in_valid = 1'b1; m_tag = 5'h1B;
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", m_out_valid, 1'b0);
    check("ar_out_result", m_out_result, 32'h0);
    check("ar_out_tag", m_out_tag, 5'h0);
    #2 reset = 1'b0;
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_stale", m_out_valid, 1'b0);
    end

    // Random sweep across the extra configurations
    sweep_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r_valid     = ($urandom_range(0, 3) != 0);
      r_src1      = pick();
      r_src2      = pick();
      r_mode      = 2'($urandom_range(0, 3));
      r_tag       = 5'($urandom_range(0, 31));
      r_out_ready = ($urandom_range(0, 3) != 0);
      r_flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    r_valid = 1'b0; r_flush = 1'b0; r_out_ready = 1'b1;
    repeat (8) tick();
    drain_chk = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_mult_pipe.md
Name: nios_mult_pipe

Overview:
- Parametrised, pipelined integer multiply unit for the NiosII CPU datapath; successor to the fixed 32x32-low-only multiply cell.
- Adds signed/unsigned operand modes, high-half result select (mul, mulxss, mulxsu, mulxuu) and configurable width and latency.
- Adds a valid/ready handshake with backpressure and flush, so the execute stage can stall or kill in-flight operations.
- Sits between the A-stage operand muxes and the writeback result mux.

Parameters:
- DATA_W, 32, operand and result width; must be even and >= 8.
- LATENCY, 2, cycles from accept to out_valid with no backpressure; legal range 1..4.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- in_mode  in  2  00 LO, 01 HI_SS, 10 HI_SU (A signed, B unsigned), 11 HI_UU
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  DATA_W  selected product half
- out_tag  out  TAG_W  tag of the operation in out_result

Behaviour:
- Reset (async assert, sync release): all stage valid bits are 0, out_valid=0, out_result=0, out_tag=0, in_ready=1 after release.
- Arithmetic:
  - Each operand is extended to DATA_W+1 bits: sign-extended if its mode says signed, else zero-extended.
  - The full product is formed to 2*DATA_W bits.
  - LO returns product[DATA_W-1:0], which is identical for all signedness.
  - HI_* modes return product[2*DATA_W-1:DATA_W].
- Implementation: four (DATA_W/2)x(DATA_W/2) unsigned partial products with signed correction terms, summed in the final stage.
- Pipeline: LATENCY register stages, each holding valid, mode, tag and partial data.
  - Stage 1 registers the partial products.
  - The last stage registers the summed, selected result.
  - Intermediate stages (LATENCY>2) are pure delay.
  - For LATENCY=1 all arithmetic sits in one stage.
- Handshake:
  - Global advance = !out_valid || out_ready.
  - in_ready = advance.
  - An operation is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its contents and out_result/out_tag stay stable.
  - A bubble (in_valid=0 while advancing) shifts in valid=0.
  - Back-to-back accepts give one result per cycle. Throughput is 1/cycle when out_ready=1.
- Latency: an operation accepted at cycle N with out_ready held high gives out_valid=1 at cycle N+LATENCY.
- flush:
  - Next cycle, all stage valid bits are 0 and out_valid=0.
  - An operation offered in the same cycle as flush is NOT accepted, even if in_ready=1.
  - Data registers may keep stale values.
- Simultaneous out_ready and new accept with a full pipe: the result leaves and everything shifts; no loss, no duplication.
- Reset mid-operation: all in-flight operations are discarded; no partial result is ever presented.
- out_result and out_tag hold the last value while out_valid=0; consumers must ignore them.

Decomposition:
- Shared package nios_mult_pkg holds:
  - mode constants MODE_LO, MODE_HI_SS, MODE_HI_SU, MODE_HI_UU;
  - a function for operand extension by mode;
  - the stage-payload typedef (valid, mode, tag, data).
- One sub-module, nios_mult_pp: registered (DATA_W/2)x(DATA_W/2) unsigned multiplier with enable, instantiated 4 times, so synthesis maps each onto a dedicated DSP block.

Test Plan:
- Reset and basic latency (LATENCY=2): src1=7, src2=6, mode LO, tag 3, out_ready=1 -> out_valid exactly 2 cycles later, result 0x0000002A, tag 3; out_valid=0 before that.
- All modes, src1=src2=0xFFFFFFFF -> LO 0x00000001, HI_SS 0x00000000, HI_SU 0xFFFFFFFF, HI_UU 0xFFFFFFFE.
- Corner operands, src1=src2=0x80000000 -> HI_SS 0x40000000, HI_UU 0x40000000, LO 0x00000000.
- Backpressure: stream 4 ops (tags 0..3), drop out_ready for 3 cycles after the first result.
  - in_ready must fall on that cycle.
  - Results must be held stable while stalled.
  - All 4 must emerge in order with no duplicates.
- Flush: two ops in flight plus in_valid=1 with flush=1 -> no out_valid for any of the three; the next op after flush completes normally with correct tag.
- Async reset asserted mid-stream, then a random sweep:
  - Outputs go to 0 immediately on the reset edge and no stale result appears after release.
  - 10k random operand/mode/tag/out_ready cycles are checked against a 64-bit reference model for DATA_W=32 and DATA_W=16, LATENCY 1..4.
